// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code sequence source: FSM state encoding
// and the default counter width.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage : gray_pkg

// File: rtl/bin2gray.sv
// Purely combinational binary-to-Gray encoder, WIDTH bits in and out.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Each Gray bit is the XOR of a binary bit and its more significant neighbour.
    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule : bin2gray

// File: rtl/gray_seq_gen.sv
// Gray-code sequence source: registered binary counter, Gray encoding of the
// next count, valid/ready output handshake, start/stop/drain FSM and a wrap
// pulse on counter roll-over.
//
// Optional feature macro: GRAY_SEQ_DOWN_EN adds the dir port and down-counting.
//
// Handshake: a word transfers on every rising edge where valid=1 and ready=1.
// While valid=1 and no transfer occurs, dout and bin hold; valid only falls
// on the cycle after a transfer.
//
// state_dbg exposes the FSM state register for observation.
module gray_seq_gen
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef GRAY_SEQ_DOWN_EN
    input  logic             dir,
`endif
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] bin,
    output logic             wrap,
    output logic             busy,
    output state_t           state_dbg
);

    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             step_down;
    logic [WIDTH-1:0] bin_step;
    logic             wrap_hit;

`ifdef GRAY_SEQ_DOWN_EN
    assign step_down = dir;
`else
    assign step_down = 1'b0;
`endif

    // Counter step and roll-over detection for the direction sampled this cycle.
    always_comb begin
        accept   = valid_q & ready;
        bin_step = step_down ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
        wrap_hit = step_down ? (bin_q == '0) : (bin_q == BIN_MAX);
    end

    // Next-state logic for the FSM, the counter and the registered outputs.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // stop is ignored here; start alone decides the transition.
                if (start) begin
                    state_d = RUN;
                    bin_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    bin_d  = bin_step;
                    wrap_d = wrap_hit;
                    if (stop) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Hold the word until it is taken, then finish.
                if (accept) begin
                    bin_d   = bin_step;
                    wrap_d  = wrap_hit;
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // dout is encoded from the same next-bin value that loads bin_q.
    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (bin_d),
        .gray (dout_d)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    assign valid     = valid_q;
    assign dout      = dout_q;
    assign bin       = bin_q;
    assign wrap      = wrap_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule : gray_seq_gen
